// File: rtl/fx2_tx_arbiter.sv
// fx2_tx_arbiter: shares the FX2 FPGA-to-PC byte path between the time-tag record
// stream and the command-reply stream, never splitting a record or message.
module fx2_tx_arbiter #(
    parameter int REC_BYTES      = 6,
    parameter int REPLY_MAX_MSGS = 4
) (
    input  logic        FX2_CLK,
    input  logic        RESET,
    input  logic [7:0]  DATA_BYTE,
    input  logic        DATA_VALID,
    output logic        DATA_READY,
    input  logic [7:0]  REPLY_BYTE,
    input  logic        REPLY_VALID,
    input  logic        REPLY_LAST,
    output logic        REPLY_READY,
    output logic [7:0]  FPGA_WORD,
    output logic        FPGA_WORD_AVAILABLE,
    input  logic        FPGA_WORD_ACCEPTED,
    input  logic        REQUEST_LENGTH,
    output logic [15:0] LENGTH,
    output logic [1:0]  GRANT
);
    // state | meaning
    // IDLE  | no grant; the next owner is chosen on the clock edge
    // DATA  | record stream owns the path until REC_BYTES bytes have transferred
    // REPLY | reply stream owns the path until the REPLY_LAST byte transfers
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DATA  = 2'b01,
        REPLY = 2'b10
    } state_t;

    localparam logic [7:0] REC_LAST   = 8'(REC_BYTES - 1);
    localparam logic [3:0] STREAK_MAX = 4'(REPLY_MAX_MSGS);

    state_t      state, state_nxt;
    logic [7:0]  rec_idx, rec_idx_nxt;
    logic [3:0]  streak, streak_nxt;
    logic [15:0] run_cnt, run_cnt_nxt, length_nxt, cnt_sat;
    logic [16:0] cnt_inc;
    logic        xfer;

    always_comb begin
        FPGA_WORD           = 8'h00;
        FPGA_WORD_AVAILABLE = 1'b0;
        DATA_READY          = 1'b0;
        REPLY_READY         = 1'b0;
        case (state)
            DATA: begin
                FPGA_WORD           = DATA_BYTE;
                FPGA_WORD_AVAILABLE = DATA_VALID;
                DATA_READY          = FPGA_WORD_ACCEPTED & DATA_VALID;
            end
            REPLY: begin
                FPGA_WORD           = REPLY_BYTE;
                FPGA_WORD_AVAILABLE = REPLY_VALID;
                REPLY_READY         = FPGA_WORD_ACCEPTED & REPLY_VALID;
            end
            default: ;
        endcase
    end

    assign xfer  = FPGA_WORD_AVAILABLE & FPGA_WORD_ACCEPTED;
    assign GRANT = state;

    always_comb begin
        state_nxt   = state;
        rec_idx_nxt = rec_idx;
        streak_nxt  = streak;
        case (state)
            IDLE: begin
                // Streak only limits replies while record data is actually waiting.
                if (!DATA_VALID)
                    streak_nxt = 4'd0;
                if (REPLY_VALID && ((streak < STREAK_MAX) || !DATA_VALID)) begin
                    state_nxt = REPLY;
                end else if (DATA_VALID) begin
                    state_nxt  = DATA;
                    streak_nxt = 4'd0;
                end
            end
            DATA: begin
                if (xfer) begin
                    if (rec_idx == REC_LAST) begin
                        rec_idx_nxt = 8'd0;
                        state_nxt   = IDLE;
                    end else begin
                        rec_idx_nxt = rec_idx + 8'd1;
                    end
                end
            end
            REPLY: begin
                if (xfer && REPLY_LAST) begin
                    state_nxt = IDLE;
                    if (streak != 4'hF)
                        streak_nxt = streak + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cnt_inc = {1'b0, run_cnt} + {16'd0, xfer};
    assign cnt_sat = cnt_inc[16] ? 16'hFFFF : cnt_inc[15:0];

    // The snapshot includes a transfer landing in the same cycle as the request.
    always_comb begin
        run_cnt_nxt = cnt_sat;
        length_nxt  = LENGTH;
        if (REQUEST_LENGTH) begin
            length_nxt  = cnt_sat;
            run_cnt_nxt = 16'd0;
        end
    end

    always_ff @(posedge FX2_CLK) begin
        if (RESET) begin
            state   <= IDLE;
            rec_idx <= 8'd0;
            streak  <= 4'd0;
            run_cnt <= 16'd0;
            LENGTH  <= 16'd0;
        end else begin
            state   <= state_nxt;
            rec_idx <= rec_idx_nxt;
            streak  <= streak_nxt;
            run_cnt <= run_cnt_nxt;
            LENGTH  <= length_nxt;
        end
    end

endmodule

// File: tb/tb_fx2_tx_arbiter.sv
// tb_fx2_tx_arbiter: cycle vectors, directed corner sequences and a randomized run
// scored against queue models of the two upstream streams and the byte count.
module tb_fx2_tx_arbiter;
    localparam int REC  = 6;
    localparam int MAXM = 4;

    logic        FX2_CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  DATA_BYTE = 8'h00;
    logic        DATA_VALID = 1'b0;
    logic        DATA_READY;
    logic [7:0]  REPLY_BYTE = 8'h00;
    logic        REPLY_VALID = 1'b0;
    logic        REPLY_LAST = 1'b0;
    logic        REPLY_READY;
    logic [7:0]  FPGA_WORD;
    logic        FPGA_WORD_AVAILABLE;
    logic        FPGA_WORD_ACCEPTED = 1'b0;
    logic        REQUEST_LENGTH = 1'b0;
    logic [15:0] LENGTH;
    logic [1:0]  GRANT;

    fx2_tx_arbiter #(.REC_BYTES(REC), .REPLY_MAX_MSGS(MAXM)) dut (
        .FX2_CLK(FX2_CLK), .RESET(RESET),
        .DATA_BYTE(DATA_BYTE), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
        .REPLY_BYTE(REPLY_BYTE), .REPLY_VALID(REPLY_VALID), .REPLY_LAST(REPLY_LAST),
        .REPLY_READY(REPLY_READY),
        .FPGA_WORD(FPGA_WORD), .FPGA_WORD_AVAILABLE(FPGA_WORD_AVAILABLE),
        .FPGA_WORD_ACCEPTED(FPGA_WORD_ACCEPTED),
        .REQUEST_LENGTH(REQUEST_LENGTH), .LENGTH(LENGTH), .GRANT(GRANT)
    );

    always #5 FX2_CLK = ~FX2_CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       dv;
        logic [7:0] db;
        logic       rv;
        logic [7:0] rb;
        logic       rl;
        logic       req;
        logic [1:0] e_grant;
        logic       e_avail;
        logic [7:0] e_word;
        logic       e_drdy;
        logic       e_rrdy;
        logic [15:0] e_len;
    } vec_t;

    vec_t vecs[$];

    int n_tests = 0;
    int n_fail  = 0;

    // upstream stream models and scoreboard state
    logic [7:0] dq[$];
    logic [7:0] rq[$];
    bit         rl[$];
    int         unit_log[$];
    int         cur_src = 0;
    int         unit_bytes = 0;
    bit         must_idle = 0;
    bit         prev_hold = 0;
    logic [7:0] prev_word = 8'h00;
    int         cnt = 0;
    int         exp_len = 0;
    int         data_xfers = 0;
    int         reply_xfers = 0;
    bit         s_drdy = 0;
    bit         s_rrdy = 0;
    bit         tog = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic vec_t mk(input logic dv, input logic [7:0] db, input logic rv,
                                input logic [7:0] rb, input logic rlast, input logic req,
                                input logic [1:0] eg, input logic [7:0] ew,
                                input logic [15:0] el);
        vec_t v;
        v.dv = dv; v.db = db; v.rv = rv; v.rb = rb; v.rl = rlast; v.req = req;
        v.e_grant = eg;
        v.e_avail = (eg != 2'b00);
        v.e_word  = ew;
        v.e_drdy  = (eg == 2'b01);
        v.e_rrdy  = (eg == 2'b10);
        v.e_len   = el;
        return v;
    endfunction

    task automatic reset_model();
        cnt = 0; exp_len = 0; cur_src = 0; unit_bytes = 0;
        must_idle = 0; prev_hold = 0; s_drdy = 0; s_rrdy = 0;
    endtask

    // Runs at the falling edge: scores the transfer (if any) of the current cycle.
    task automatic monitor();
        bit x;
        if (RESET) begin
            reset_model();
            return;
        end
        x = FPGA_WORD_AVAILABLE && FPGA_WORD_ACCEPTED;
        check("length_hold", LENGTH, exp_len);
        check("ready_vs_transfer", int'(DATA_READY) + int'(REPLY_READY), int'(x));
        if (must_idle) begin
            check("idle_between_units", {GRANT, FPGA_WORD_AVAILABLE}, 3'b000);
            must_idle = 0;
        end
        if (cur_src == 1) begin
            check("record_avail_follows_valid", FPGA_WORD_AVAILABLE, DATA_VALID);
            check("no_reply_inside_record", REPLY_READY, 0);
        end
        if (cur_src == 2) begin
            check("reply_avail_follows_valid", FPGA_WORD_AVAILABLE, REPLY_VALID);
            check("no_record_inside_reply", DATA_READY, 0);
        end
        if (prev_hold && FPGA_WORD_AVAILABLE)
            check("word_stable_while_waiting", FPGA_WORD, prev_word);
        if (GRANT == 2'b00)
            check("idle_word_zero", {FPGA_WORD, FPGA_WORD_AVAILABLE}, 9'd0);
        if (DATA_READY) begin
            check("data_grant", GRANT, 2'b01);
            if (dq.size() > 0) check("data_byte", FPGA_WORD, dq[0]);
            if (cur_src == 0) begin cur_src = 1; unit_bytes = 0; end
            unit_bytes++;
            if (unit_bytes == REC) begin
                cur_src = 0; must_idle = 1; unit_log.push_back(1);
            end
            data_xfers++;
        end
        if (REPLY_READY) begin
            check("reply_grant", GRANT, 2'b10);
            if (rq.size() > 0) check("reply_byte", FPGA_WORD, rq[0]);
            if (cur_src == 0) cur_src = 2;
            if (REPLY_LAST) begin
                cur_src = 0; must_idle = 1; unit_log.push_back(2);
            end
            reply_xfers++;
        end
        prev_hold = FPGA_WORD_AVAILABLE && !FPGA_WORD_ACCEPTED;
        prev_word = FPGA_WORD;
        if (REQUEST_LENGTH) begin
            exp_len = sat16(cnt + int'(x));
            cnt = 0;
        end else begin
            cnt = sat16(cnt + int'(x));
        end
        s_drdy = DATA_READY;
        s_rrdy = REPLY_READY;
    endtask

    task automatic step();
        @(negedge FX2_CLK);
        monitor();
        @(posedge FX2_CLK);
        #1;
    endtask

    // acc_mode: 0 always accept, 1 alternate, 2 random
    task automatic drive(input int acc_mode, input int pct, input bit req_rand);
        if (s_drdy && dq.size() > 0) void'(dq.pop_front());
        if (s_rrdy && rq.size() > 0) begin
            void'(rq.pop_front());
            void'(rl.pop_front());
        end
        s_drdy = 0; s_rrdy = 0;
        DATA_VALID  = (dq.size() > 0) && ($urandom_range(99) < pct);
        DATA_BYTE   = (dq.size() > 0) ? dq[0] : 8'h00;
        REPLY_VALID = (rq.size() > 0) && ($urandom_range(99) < pct);
        REPLY_BYTE  = (rq.size() > 0) ? rq[0] : 8'h00;
        REPLY_LAST  = (rl.size() > 0) ? rl[0] : 1'b0;
        tog = ~tog;
        case (acc_mode)
            0: FPGA_WORD_ACCEPTED = 1'b1;
            1: FPGA_WORD_ACCEPTED = tog;
            default: FPGA_WORD_ACCEPTED = ($urandom_range(3) != 0);
        endcase
        REQUEST_LENGTH = req_rand && ($urandom_range(19) == 0);
    endtask

    task automatic run_stream(input int acc_mode, input int pct, input bit req_rand,
                              input int budget, input string name);
        for (int c = 0; c < budget; c++) begin
            drive(acc_mode, pct, req_rand);
            if (dq.size() == 0 && rq.size() == 0) break;
            step();
        end
        REQUEST_LENGTH = 1'b0;
        check({name, "_drained"}, dq.size() + rq.size(), 0);
        step();
    endtask

    task automatic push_msg(input int len, input int base);
        for (int i = 0; i < len; i++) begin
            rq.push_back(8'(base + i));
            rl.push_back(i == len - 1);
        end
    endtask

    task automatic push_rec(input int base);
        for (int i = 0; i < REC; i++) dq.push_back(8'(base + i));
    endtask

    task automatic pulse_request();
        REQUEST_LENGTH = 1'b1;
        step();
        REQUEST_LENGTH = 1'b0;
    endtask

    initial begin
        int d0, r0, rsum;

        // record-only pair, then a reply arriving while record byte 2 is out
        for (int i = 0; i < 16; i++) begin
            if (i == 0)       vecs.push_back(mk(1, 8'h10, 0, 0, 0, 0, 2'b00, 8'h00, 0));
            else if (i <= 6)  vecs.push_back(mk(1, 8'(8'h10 + i - 1), 0, 0, 0, 0, 2'b01, 8'(8'h10 + i - 1), 0));
            else if (i == 7)  vecs.push_back(mk(1, 8'h16, 0, 0, 0, 0, 2'b00, 8'h00, 0));
            else if (i <= 13) vecs.push_back(mk(1, 8'(8'h16 + i - 8), 0, 0, 0, 0, 2'b01, 8'(8'h16 + i - 8), 0));
            else if (i == 14) vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 2'b00, 8'h00, 0));
            else              vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 2'b00, 8'h00, 16'd12));
        end
        vecs.push_back(mk(1, 8'h30, 0, 8'h00, 0, 0, 2'b00, 8'h00, 16'd12));
        vecs.push_back(mk(1, 8'h30, 0, 8'h00, 0, 0, 2'b01, 8'h30, 16'd12));
        vecs.push_back(mk(1, 8'h31, 0, 8'h00, 0, 0, 2'b01, 8'h31, 16'd12));
        vecs.push_back(mk(1, 8'h32, 1, 8'hA1, 0, 0, 2'b01, 8'h32, 16'd12));
        vecs.push_back(mk(1, 8'h33, 1, 8'hA1, 0, 0, 2'b01, 8'h33, 16'd12));
        vecs.push_back(mk(1, 8'h34, 1, 8'hA1, 0, 0, 2'b01, 8'h34, 16'd12));
        vecs.push_back(mk(1, 8'h35, 1, 8'hA1, 0, 0, 2'b01, 8'h35, 16'd12));
        vecs.push_back(mk(0, 8'h00, 1, 8'hA1, 0, 0, 2'b00, 8'h00, 16'd12));
        vecs.push_back(mk(0, 8'h00, 1, 8'hA1, 0, 0, 2'b10, 8'hA1, 16'd12));
        vecs.push_back(mk(0, 8'h00, 1, 8'hA2, 0, 0, 2'b10, 8'hA2, 16'd12));
        vecs.push_back(mk(0, 8'h00, 1, 8'hA3, 1, 0, 2'b10, 8'hA3, 16'd12));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 2'b00, 8'h00, 16'd12));

        @(posedge FX2_CLK); #1;
        step();
        step();
        RESET = 1'b0;
        step();
        check("reset_grant", GRANT, 2'b00);
        check("reset_outputs", {FPGA_WORD_AVAILABLE, DATA_READY, REPLY_READY, FPGA_WORD}, 11'd0);
        check("reset_length", LENGTH, 16'd0);

        FPGA_WORD_ACCEPTED = 1'b1;
        foreach (vecs[i]) begin
            DATA_VALID = vecs[i].dv;  DATA_BYTE  = vecs[i].db;
            REPLY_VALID = vecs[i].rv; REPLY_BYTE = vecs[i].rb;
            REPLY_LAST = vecs[i].rl;  REQUEST_LENGTH = vecs[i].req;
            @(negedge FX2_CLK);
            check($sformatf("vec%0d_grant", i), GRANT, vecs[i].e_grant);
            check($sformatf("vec%0d_avail", i), FPGA_WORD_AVAILABLE, vecs[i].e_avail);
            check($sformatf("vec%0d_word", i), FPGA_WORD, vecs[i].e_word);
            check($sformatf("vec%0d_ready", i), {DATA_READY, REPLY_READY},
                  {vecs[i].e_drdy, vecs[i].e_rrdy});
            check($sformatf("vec%0d_length", i), LENGTH, vecs[i].e_len);
            monitor();
            @(posedge FX2_CLK); #1;
        end
        REQUEST_LENGTH = 1'b0;
        step();

        // both streams always valid: four 1-byte replies per record
        unit_log.delete();
        push_rec(8'h40);
        push_rec(8'h46);
        for (int k = 0; k < 10; k++) push_msg(1, 8'hC0 + k);
        run_stream(0, 100, 0, 200, "fairness");
        check("fair_unit_count", unit_log.size(), 12);
        for (int k = 0; k < 10 && k < unit_log.size(); k++)
            check($sformatf("fair_order%0d", k), unit_log[k], (k == 4 || k == 9) ? 1 : 2);

        // alternating accept, three records
        d0 = data_xfers;
        for (int k = 0; k < 3; k++) push_rec(8'h50 + REC * k);
        run_stream(1, 100, 0, 200, "toggle_accept");
        check("toggle_bytes", data_xfers - d0, 18);

        // byte count snapshots
        pulse_request();
        push_msg(700, 0);
        run_stream(0, 100, 0, 800, "len700");
        pulse_request();
        check("len_700", LENGTH, 16'h02BC);
        push_msg(6, 8'h60);
        for (int c = 0; c < 50; c++) begin
            drive(0, 100, 0);
            if (rq.size() == 0) break;
            REQUEST_LENGTH = (rq.size() == 1);
            step();
        end
        check("len_coincide", LENGTH, 16'd6);
        pulse_request();
        check("len_repeat", LENGTH, 16'd0);
        push_msg(70000, 0);
        run_stream(0, 100, 0, 75000, "len_sat");
        pulse_request();
        check("len_saturate", LENGTH, 16'hFFFF);

        // reset in the middle of a record
        push_msg(291, 8'h20);
        run_stream(0, 100, 0, 400, "len0123");
        pulse_request();
        check("len_0123", LENGTH, 16'h0123);
        push_rec(8'h70);
        for (int c = 0; c < 50; c++) begin
            drive(0, 100, 0);
            if (dq.size() <= 3) break;
            step();
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("rst_grant", GRANT, 2'b00);
        check("rst_avail", FPGA_WORD_AVAILABLE, 1'b0);
        check("rst_length", LENGTH, 16'd0);
        dq.delete();
        unit_log.delete();
        d0 = data_xfers;
        push_rec(8'h80);
        run_stream(0, 100, 0, 50, "after_reset");
        check("after_reset_bytes", data_xfers - d0, REC);
        check("after_reset_units", unit_log.size(), 1);

        // randomized traffic
        d0 = data_xfers;
        r0 = reply_xfers;
        rsum = 0;
        for (int k = 0; k < 25; k++) push_rec(int'($urandom_range(255)));
        for (int k = 0; k < 20; k++) begin
            int len;
            len = int'($urandom_range(5, 1));
            rsum += len;
            push_msg(len, int'($urandom_range(255)));
        end
        run_stream(2, 80, 1, 5000, "random");
        check("random_record_bytes", data_xfers - d0, 25 * REC);
        check("random_reply_bytes", reply_xfers - r0, rsum);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
